// File: rtl/ex_stream_pkg.sv
// Shared types and defaults for the ex_stream transmit path.
// EX_STREAM_TX_UNDERRUN_EN enables the underrun counter in ex_stream_tx.
package ex_stream_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int FIFO_DEPTH_DEF = 8;
    localparam int UNDERRUN_W     = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tx_state_e;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/ex_stream_fifo.sv
// Single-clock FIFO with registered head (no fall-through).
// Pointers carry one extra MSB so full and empty can be told apart.
module ex_stream_fifo
    import ex_stream_pkg::*;
#(
    parameter int DW    = DATA_WIDTH_DEF,
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DW-1:0]         wdata,
    input  logic                  pop,
    output logic [DW-1:0]         rdata,
    output logic                  full,
    output logic                  empty,
    output logic [ptr_w(DEPTH):0] level
);

    localparam int AW = ptr_w(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign level   = wr_ptr - rd_ptr;
    assign rdata   = mem[rd_ptr[AW-1:0]];
    // Full blocks the push even if a pop frees a slot in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/ex_stream_tx.sv
// Buffers valid/ready input words and replays them as paced data_out + ce.
// Optional underrun_cnt output when EX_STREAM_TX_UNDERRUN_EN is defined.
module ex_stream_tx
    import ex_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int RATE_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic                       enable,
    input  logic [RATE_WIDTH-1:0]      rate,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       ce,
    output logic [ptr_w(FIFO_DEPTH):0] fifo_level
`ifdef EX_STREAM_TX_UNDERRUN_EN
    ,output logic [UNDERRUN_W-1:0]     underrun_cnt
`endif
);

    tx_state_e             state;
    logic [RATE_WIDTH-1:0] cnt;
    logic [DATA_WIDTH-1:0] head;
    logic                  full;
    logic                  empty;
    logic                  tick;
    logic                  pop;

    assign s_ready = !full;
    assign tick    = (state == ST_RUN) && (cnt == rate);
    assign pop     = tick && !empty;

    ex_stream_fifo #(
        .DW    (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s_valid),
        .wdata (s_data),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            data_out <= '0;
            ce       <= 1'b0;
        end else begin
            ce <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (enable) state <= ST_RUN;
                end
                ST_RUN: begin
                    // A counter above a newly lowered rate wraps through 0 naturally.
                    cnt <= tick ? '0 : cnt + 1'b1;
                    if (pop) begin
                        data_out <= head;
                        ce       <= 1'b1;
                    end
                    if (!enable) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef EX_STREAM_TX_UNDERRUN_EN
    always_ff @(posedge clk) begin
        if (rst)
            underrun_cnt <= '0;
        else if (tick && empty && (underrun_cnt != {UNDERRUN_W{1'b1}}))
            underrun_cnt <= underrun_cnt + 1'b1;
    end
`endif

endmodule
